// File: rtl/mode_power_encoder_pkg.sv
// Shared definitions for the climate-channel config word: widths, FSM states
// and the single definition of how power parity maps to heat/cool mode.
package mode_power_encoder_pkg;

    localparam int CONF_W    = 8;
    localparam int MAX_POWER = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        DONE = 2'd2
    } state_t;

    // Odd power is heat (1), even power is cool (0).
    function automatic logic power_mode(input logic [3:0] power);
        return power[0];
    endfunction

endpackage

// File: rtl/mode_power_encoder_step_timer.sv
// Step tick generator: counts 0..STEP_CYCLES-1 while not cleared and pulses
// tick on the last count, so a step lands every STEP_CYCLES cycles.
module mode_power_encoder_step_timer #(
    parameter int STEP_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    output logic o_tick
);

    localparam logic [7:0] LAST = 8'(STEP_CYCLES - 1);

    logic [7:0] r_cnt;

    assign o_tick = !i_clr && (r_cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 8'd0;
        end else if (i_clr || r_cnt == LAST) begin
            r_cnt <= 8'd0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/mode_power_encoder.sv
// Drives a thermometer-coded channel config word toward a requested power and
// mode, one bit per step, so the downstream decoder recovers exactly that pair.
module mode_power_encoder
    import mode_power_encoder_pkg::*;
#(
    parameter int STEP_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_power,
    input  logic       req_mode,
    input  logic       abort,
    output logic [7:0] chs_conf,
    output logic [3:0] chs_cur_power,
    output logic       busy,
    output logic       done,
    output logic       err
);

    state_t            r_state;
    logic [CONF_W-1:0] r_conf;
    logic [3:0]        r_cur;
    logic [3:0]        r_target;
    logic              r_done;
    logic              r_err;

    logic              w_clr;
    logic              w_tick;
    logic              w_up;
    logic [3:0]        w_next_cur;

    // Timer only runs in RAMP; an abort clears it and suppresses a coincident step.
    assign w_clr      = (r_state != RAMP) || abort;
    assign w_up       = r_target > r_cur;
    assign w_next_cur = w_up ? r_cur + 4'd1 : r_cur - 4'd1;

    mode_power_encoder_step_timer #(
        .STEP_CYCLES(STEP_CYCLES)
    ) u_step_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_clr),
        .o_tick(w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_conf   <= '0;
            r_cur    <= 4'd0;
            r_target <= 4'd0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        if (req_power > 4'(MAX_POWER)) begin
                            r_err <= 1'b1;
                        end else if (req_mode != power_mode(req_power)) begin
                            r_err <= 1'b1;
                        end else if (req_power == r_cur) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_target <= req_power;
                            r_state  <= RAMP;
                        end
                    end
                end
                RAMP: begin
                    if (abort) begin
                        r_state <= IDLE;
                    end else if (w_tick) begin
                        // Shifting keeps the word thermometer-coded: one bit per step.
                        r_conf <= w_up ? {r_conf[CONF_W-2:0], 1'b1}
                                       : {1'b0, r_conf[CONF_W-1:1]};
                        r_cur  <= w_next_cur;
                        if (w_next_cur == r_target) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign req_ready     = (r_state == IDLE);
    assign busy          = (r_state == RAMP);
    assign chs_conf      = r_conf;
    assign chs_cur_power = r_cur;
    assign done          = r_done;
    assign err           = r_err;

endmodule
